// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Purpose  : EX-stage ALU. AND/OR/ADD/SUB/SLT complete in one cycle.
//            Unsigned MUL (shift-add) and DIV (restoring) iterate once per
//            bit. The controller stalls on busy and captures results on done.
// Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             dz
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_MUL = 4'b1000;
    localparam logic [3:0] c_OP_DIV = 4'b1001;

    // Iteration index of the final multiply/divide step
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // MUL: {high half, low half} of the shifting product.
    // DIV: {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic               r_zero;
    logic               r_dz;

    logic               w_accept;
    logic               w_slt;
    logic [WIDTH-1:0]   w_single;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_diff;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic               w_fin_en;
    logic [WIDTH-1:0]   w_fin_res;
    logic [WIDTH-1:0]   w_fin_hi;
    logic               w_fin_dz;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_slt    = $signed(a) < $signed(b);

    // Shift-add step: add multiplicand to the upper half when the LSB is set,
    // then shift the whole accumulator right, carry included.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: shift next dividend bit into the remainder and try to
    // subtract the divisor; the borrow bit decides the quotient bit.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_rem_diff = w_rem_sh - {1'b0, r_b};
    assign w_div_nxt  = w_rem_diff[WIDTH]
                      ? {w_rem_sh[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b0}
                      : {w_rem_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign busy   = (r_state == S_MUL) || (r_state == S_DIV);
    assign done   = (r_state == S_FIN);
    assign result = r_result;
    assign hi     = r_hi;
    assign zero   = r_zero;
    assign dz     = r_dz;

    // Single-cycle operation result straight from the live operands
    always_comb begin
        w_single = '0;
        case (aluop)
            c_OP_AND: w_single = a & b;
            c_OP_OR:  w_single = a | b;
            c_OP_ADD: w_single = a + b;
            c_OP_SUB: w_single = a - b;
            c_OP_SLT: w_single = {{(WIDTH-1){1'b0}}, w_slt};
            default:  w_single = '0;
        endcase
    end

    // Select what (if anything) completes on this edge
    always_comb begin
        w_fin_en  = 1'b0;
        w_fin_res = '0;
        w_fin_hi  = '0;
        w_fin_dz  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (aluop == c_OP_DIV) begin
                        if (b == '0) begin
                            w_fin_en  = 1'b1;
                            w_fin_res = '1;
                            w_fin_hi  = a;
                            w_fin_dz  = 1'b1;
                        end
                    end else if (aluop != c_OP_MUL) begin
                        w_fin_en  = 1'b1;
                        w_fin_res = w_single;
                    end
                end
            end
            S_MUL: begin
                if (r_cnt == c_LAST) begin
                    w_fin_en  = 1'b1;
                    w_fin_res = w_mul_nxt[WIDTH-1:0];
                    w_fin_hi  = w_mul_nxt[2*WIDTH-1:WIDTH];
                end
            end
            S_DIV: begin
                if (r_cnt == c_LAST) begin
                    w_fin_en  = 1'b1;
                    w_fin_res = w_div_nxt[WIDTH-1:0];
                    w_fin_hi  = w_div_nxt[2*WIDTH-1:WIDTH];
                end
            end
            default: w_fin_en = 1'b0;
        endcase
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (aluop == c_OP_MUL) begin
                        w_state_nxt = S_MUL;
                    end else if ((aluop == c_OP_DIV) && (b != '0)) begin
                        w_state_nxt = S_DIV;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture and iterative multiply/divide datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_cnt <= '0;
            r_acc <= (aluop == c_OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
        end else if (r_state == S_MUL) begin
            r_acc <= w_mul_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (r_state == S_DIV) begin
            r_acc <= w_div_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Architectural outputs change only when an operation completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b1;
            r_dz     <= 1'b0;
        end else if (w_fin_en) begin
            r_result <= w_fin_res;
            r_hi     <= w_fin_hi;
            r_zero   <= (w_fin_res == '0);
            r_dz     <= w_fin_dz;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Purpose  : Scoreboard bench for alu_multicycle at WIDTH=32 and WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        dz;
        int          due;
        int          busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_v [2];
    logic [3:0]  op_v    [2];
    logic [31:0] a_v     [2];
    logic [31:0] b_v     [2];

    logic        busy0, done0, zero0, dz0;
    logic [31:0] res0, hi0;
    logic        busy1, done1, zero1, dz1;
    logic [7:0]  res1, hi1;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] last_res  [2];
    logic [31:0] last_hi   [2];
    logic        last_zero [2];
    logic        last_dz   [2];
    int          busy_cnt  [2];

    alu_multicycle #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .aluop(op_v[0]),
        .a(a_v[0]), .b(b_v[0]), .busy(busy0), .done(done0),
        .result(res0), .hi(hi0), .zero(zero0), .dz(dz0)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .aluop(op_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .busy(busy1), .done(done1),
        .result(res1), .hi(hi1), .zero(zero1), .dz(dz1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour: plain arithmetic on WIDTH-bit unsigned values
    function automatic exp_t model(input int d, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int w;
        int lat;
        longint unsigned m, ua, ub, p, r, h;
        longint sa, sb;
        w  = d ? 8 : 32;
        m  = (64'd1 << w) - 64'd1;
        ua = 64'(a) & m;
        ub = 64'(b) & m;
        sa = ((ua >> (w - 1)) & 64'd1) != 0 ? longint'(ua) - longint'(m) - 1 : longint'(ua);
        sb = ((ub >> (w - 1)) & 64'd1) != 0 ? longint'(ub) - longint'(m) - 1 : longint'(ub);
        r = 0; h = 0; lat = 1;
        e.dz = 1'b0;
        case (op)
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_ADD: r = (ua + ub) & m;
            OP_SUB: r = (ua - ub) & m;
            OP_SLT: r = (sa < sb) ? 1 : 0;
            OP_MUL: begin
                p = ua * ub;
                r = p & m;
                h = (p >> w) & m;
                lat = w + 1;
            end
            OP_DIV: begin
                if (ub == 0) begin
                    r = m; h = ua; e.dz = 1'b1;
                end else begin
                    r = ua / ub; h = ua % ub; lat = w + 1;
                end
            end
            default: begin r = 0; h = 0; end
        endcase
        e.res  = 32'(r);
        e.hi   = 32'(h);
        e.zero = (r == 0);
        e.busy = lat - 1;
        e.due  = 0;
        return e;
    endfunction

    function automatic int qsize(input int d);
        return d ? q1.size() : q0.size();
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s dut%0d @cyc %0d: actual=%0h required=%0h", nm, d, cyc, act, req);
        end
    endtask

    task automatic hold_chk(input int d, input logic [31:0] r, input logic [31:0] h,
                            input logic z, input logic dzv);
        chk("hold_result", d, 64'(r), 64'(last_res[d]));
        chk("hold_hi", d, 64'(h), 64'(last_hi[d]));
        chk("hold_flags", d, 64'({z, dzv}), 64'({last_zero[d], last_dz[d]}));
    endtask

    task automatic mon(input int d, input logic bz, input logic dn, input logic [31:0] r,
                       input logic [31:0] h, input logic z, input logic dzv);
        exp_t e;
        if (!rst_n) begin
            chk("reset_busy", d, 64'(bz), 64'd0);
            chk("reset_done", d, 64'(dn), 64'd0);
            chk("reset_result", d, 64'(r), 64'd0);
            chk("reset_hi", d, 64'(h), 64'd0);
            chk("reset_zero", d, 64'(z), 64'd1);
            chk("reset_dz", d, 64'(dzv), 64'd0);
            if (d == 0) q0.delete(); else q1.delete();
            last_res[d] = '0; last_hi[d] = '0; last_zero[d] = 1'b1; last_dz[d] = 1'b0;
            busy_cnt[d] = 0;
        end else begin
            if (bz) busy_cnt[d]++;
            if (qsize(d) == 0) begin
                chk("spurious_done", d, 64'(dn), 64'd0);
                hold_chk(d, r, h, z, dzv);
            end else begin
                e = d ? q1[0] : q0[0];
                if (dn) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    chk("result", d, 64'(r), 64'(e.res));
                    chk("hi", d, 64'(h), 64'(e.hi));
                    chk("zero", d, 64'(z), 64'(e.zero));
                    chk("dz", d, 64'(dzv), 64'(e.dz));
                    chk("latency", d, 64'(cyc), 64'(e.due));
                    chk("busy_cycles", d, 64'(busy_cnt[d]), 64'(e.busy));
                    last_res[d] = r; last_hi[d] = h; last_zero[d] = z; last_dz[d] = dzv;
                    busy_cnt[d] = 0;
                end else if (cyc >= e.due) begin
                    chk("done_missing", d, 64'(dn), 64'd1);
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    busy_cnt[d] = 0;
                end else begin
                    hold_chk(d, r, h, z, dzv);
                end
            end
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard every cycle
    always @(negedge clk) begin
        mon(0, busy0, done0, res0, hi0, zero0, dz0);
        mon(1, busy1, done1, {24'd0, res1}, {24'd0, hi1}, zero1, dz1);
    end

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic wait_empty(input int d);
        for (int i = 0; i < 200 && qsize(d) != 0; i++) @(negedge clk);
        if (qsize(d) != 0) begin
            $display("FAIL drain_timeout dut%0d: pending=%0d required=0", d, qsize(d));
            $fatal(1, "scoreboard did not drain");
        end
    endtask

    task automatic issue(input int d, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        start_v[d] = 1'b1; op_v[d] = op; a_v[d] = a; b_v[d] = b;
        e = model(d, op, a, b);
        e.due = cyc + e.busy + 1;
        push(d, e);
        @(negedge clk);
        start_v[d] = 1'b0;
        op_v[d] = 4'($urandom); a_v[d] = $urandom; b_v[d] = $urandom;
        wait_empty(d);
    endtask

    function automatic logic [3:0] pick_op();
        case ($urandom_range(0, 9))
            0: return OP_AND;
            1: return OP_OR;
            2: return OP_ADD;
            3: return OP_SUB;
            4: return OP_SLT;
            5, 6: return OP_MUL;
            7, 8: return OP_DIV;
            default: return 4'($urandom);
        endcase
    endfunction

    initial begin
        exp_t e;
        int s;
        logic [31:0] ra, rb;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; op_v[d] = '0; a_v[d] = '0; b_v[d] = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset in the middle of a multiply: no done, outputs back to reset state
        @(negedge clk);
        start_v[0] = 1'b1; op_v[0] = OP_MUL; a_v[0] = 32'h1234_5678; b_v[0] = 32'h9ABC_DEF0;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        issue(0, OP_ADD, 32'd3, 32'd4);

        // Directed WIDTH=32 cases
        issue(0, OP_SUB, 32'd5, 32'd7);
        issue(0, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        issue(0, OP_SLT, 32'd1, 32'hFFFF_FFFF);
        issue(0, OP_AND, 32'h0000_F0F0, 32'h0000_0FF0);
        issue(0, OP_OR,  32'h0000_0000, 32'h0000_0000);
        issue(0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
        issue(0, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(0, OP_DIV, 32'd100, 32'd7);
        issue(0, OP_DIV, 32'd9, 32'd0);
        issue(0, OP_DIV, 32'hFFFF_FFFF, 32'd1);
        issue(0, 4'b1111, 32'd5, 32'd6);

        // Start held high with operands churning during MUL 6*7
        @(negedge clk);
        start_v[0] = 1'b1; op_v[0] = OP_MUL; a_v[0] = 32'd6; b_v[0] = 32'd7;
        e = model(0, OP_MUL, 32'd6, 32'd7);
        s = cyc;
        e.due = s + e.busy + 1;
        push(0, e);
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            if (cyc == s + 33) begin
                op_v[0] = OP_ADD; a_v[0] = 32'd3; b_v[0] = 32'd4;
                e = model(0, OP_ADD, 32'd3, 32'd4);
                e.due = s + 35;
                push(0, e);
            end else begin
                op_v[0] = 4'($urandom); a_v[0] = $urandom; b_v[0] = $urandom;
            end
        end
        @(negedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_empty(0);

        // Random WIDTH=32 traffic
        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
            issue(0, pick_op(), ra, rb);
        end

        // WIDTH=8 instance
        issue(1, OP_MUL, 32'd255, 32'd255);
        issue(1, OP_DIV, 32'd200, 32'd3);
        issue(1, OP_DIV, 32'd17, 32'd0);
        issue(1, OP_SLT, 32'h80, 32'h7F);
        issue(1, OP_ADD, 32'hFF, 32'h01);
        for (int i = 0; i < 60; i++) begin
            ra = 32'($urandom_range(0, 255));
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom_range(0, 255));
            issue(1, pick_op(), ra, rb);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Next-generation execute unit: WIDTH-parametrised ALU that consumes the 4-bit ALU control code produced by the ALU control decoder.
- Adds iterative multicycle unsigned multiply and divide alongside the single-cycle logic/arithmetic ops.
- Sits in the EX stage. The controller stalls on `busy` and captures results on `done`.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- aluop  in  4  control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 MUL (unsigned), 1001 DIV (unsigned).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  single-cycle pulse; result/hi valid from this cycle.
- result  out  WIDTH  low result: op result, low product, or quotient.
- hi  out  WIDTH  high product or remainder; 0 for single-cycle ops.
- zero  out  1  (result == 0), updated with result.
- dz  out  1  divide-by-zero flag, updated with result.

Behaviour:
- Reset (async assert, sync-released deassert edge): state=IDLE; busy, done, result, hi, dz = 0; zero=1; counter and internal regs = 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, MUL, DIV, FIN.
- Operand capture: a, b, aluop registered on the accepting edge. Later input changes have no effect.
- IDLE + start + single-cycle op (AND/OR/ADD/SUB/SLT):
  - result registered on the same edge; done=1 next cycle; latency 1; busy stays 0.
  - ADD/SUB wrap mod 2^WIDTH, no overflow flag.
  - SLT: result = 1 if $signed(a) < $signed(b), else 0.
- IDLE + start + undefined code: result=0, hi=0, done after 1 cycle (same as single-cycle path).
- MUL, shift-add:
  - acc[2*WIDTH-1:0] = {0, b}; one iteration per cycle for WIDTH cycles.
  - Each iteration: if acc[0], add a into acc upper half with carry; then shift right by 1.
  - Enter FIN; result = acc low half, hi = acc high half.
  - done pulses at cycle WIDTH+1 after accept; busy high cycles 1..WIDTH.
- DIV, restoring, WIDTH iterations:
  - Quotient to result, remainder to hi; same latency as MUL.
- DIV with b==0 (checked at accept): no iteration; result = all ones, hi = a, dz=1, done after 1 cycle. dz cleared on every other completion.
- FIN: assert done for exactly one cycle, return to IDLE.
- start is ignored while busy or during the done cycle. Back-to-back issue: start may be accepted in the first IDLE cycle after done drops.
- result, hi, zero, dz hold their values until the next completion. They never change while busy.
- Counter terminates exactly after WIDTH iterations; no off-by-one at counter wrap.

Test Plan:
- Reset mid-op: start MUL, assert rst_n=0 at cycle 5 -> busy=0, done never pulses, result=0, zero=1; start ADD 3+4 after release -> result=7, done at +1.
- Single-cycle ops, WIDTH=32:
  - SUB 5-7 -> result=0xFFFFFFFE, zero=0.
  - SLT 0xFFFFFFFF vs 1 -> result=1.
  - AND 0xF0F0 & 0x0FF0 -> result=0x00F0.
  - Each completes with done 1 cycle after start.
- MUL 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, result=0x00000001, done exactly 33 cycles after accept, busy high 32 cycles.
- DIV 100/7 -> result=14, hi=2, dz=0, latency 33. DIV 9/0 -> result=0xFFFFFFFF, hi=9, dz=1, latency 1.
- Start held high and operands changed during MUL 6*7 -> single done, result=42, second start accepted only after done.
- Parameter sweep WIDTH=8: MUL 255*255 -> hi=0xFE, result=0x01, latency 9; DIV 200/3 -> result=66, hi=2.
